hex_inv_tester: RTL and testbench



---
 rtl/hex_inv_pkg.sv | 18 +
 rtl/settle_timer.sv | 24 ++
 rtl/hex_inv_tester.sv | 111 +++++++++++
 tb/tb_hex_inv_tester.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_inv_pkg.sv
// Shared types and constants for the hex inverter self-test sequencer.
package hex_inv_pkg;

   localparam int NUM_CH       = 6;
   localparam int NUM_PATTERNS = 64;
   localparam int CNT_W        = 7;

   localparam logic [NUM_CH-1:0] LAST_PATTERN = 6'd63;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times the settle window after a pattern is applied.
module settle_timer (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_value,
   output logic       expired
);

   logic [7:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != 8'd0) begin
         count <= count - 8'd1;
      end
   end

   assign expired = (count == 8'd0);

endmodule

// File: rtl/hex_inv_tester.sv
// Exhaustive 64-pattern self-test of a six-channel inverter datapath.
module hex_inv_tester
   import hex_inv_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter bit STOP_ON_FAIL  = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [NUM_CH-1:0] dut_in,
   input  logic [NUM_CH-1:0] dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [NUM_CH-1:0] fail_pattern,
   output logic [NUM_CH-1:0] fail_mask,
   output logic [CNT_W-1:0]  fail_count,
   output logic [NUM_CH-1:0] pattern
);

   localparam logic [7:0] LOAD_VAL =
      (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

   state_t state;
   state_t state_n;

   logic [NUM_CH-1:0] mism;
   logic              fail_now;
   logic              last;
   logic              launch;
   logic              expired;

   assign mism     = dut_out ^ ~dut_in;
   assign fail_now = |mism;
   assign last     = (pattern == LAST_PATTERN);
   assign launch   = start && (state == IDLE || state == DONE);

   settle_timer u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (state == APPLY),
      .load_value (LOAD_VAL),
      .expired    (expired)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) state_n = APPLY;
         end
         APPLY: begin
            state_n = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
         end
         SETTLE: begin
            if (expired) state_n = CHECK;
         end
         CHECK: begin
            if (last || (STOP_ON_FAIL && fail_now))
               state_n = DONE;
            else
               state_n = APPLY;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dut_in       <= '0;
         pattern      <= '0;
         fail_pattern <= '0;
         fail_mask    <= '0;
         fail_count   <= '0;
      end else begin
         if (launch) begin
            pattern      <= '0;
            fail_pattern <= '0;
            fail_mask    <= '0;
            fail_count   <= '0;
         end
         if (state == APPLY) dut_in <= pattern;
         if (state == CHECK) begin
            if (fail_now) begin
               if (fail_count != CNT_W'(NUM_PATTERNS))
                  fail_count <= fail_count + 1'b1;
               // only the first failure is kept for diagnosis
               if (fail_count == '0) begin
                  fail_pattern <= pattern;
                  fail_mask    <= mism;
               end
            end
            if (state_n == APPLY) pattern <= pattern + 1'b1;
         end
      end
   end

   assign busy = (state == APPLY) || (state == SETTLE) || (state == CHECK);
   assign done = (state == DONE);
   assign pass = done && (fail_count == '0);

endmodule

// File: tb/tb_hex_inv_tester.sv
// Scoreboard bench: three tester configurations, each driving a faultable inverter model.
module tb_hex_inv_tester;

   localparam int S0 = 2;
   localparam int S1 = 2;
   localparam int S2 = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_v;
   logic [2:0] start_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [2:0] pass_v;
   logic [5:0] din_v [3];
   logic [5:0] dout_v [3];
   logic [5:0] pat_v [3];
   logic [5:0] fpat_v [3];
   logic [5:0] fmask_v [3];
   logic [5:0] sa0 [3];
   logic [5:0] sa1 [3];
   logic [6:0] fcnt_v [3];

   assign dout_v[0] = (~din_v[0] & ~sa0[0]) | sa1[0];
   assign dout_v[1] = (~din_v[1] & ~sa0[1]) | sa1[1];
   assign dout_v[2] = (~din_v[2] & ~sa0[2]) | sa1[2];

   hex_inv_tester #(.SETTLE_CYCLES(S0), .STOP_ON_FAIL(1'b0)) u0 (
      .clock(clk), .reset(rst_v[0]), .start(start_v[0]),
      .dut_in(din_v[0]), .dut_out(dout_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .fail_pattern(fpat_v[0]), .fail_mask(fmask_v[0]),
      .fail_count(fcnt_v[0]), .pattern(pat_v[0]));

   hex_inv_tester #(.SETTLE_CYCLES(S1), .STOP_ON_FAIL(1'b1)) u1 (
      .clock(clk), .reset(rst_v[1]), .start(start_v[1]),
      .dut_in(din_v[1]), .dut_out(dout_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .fail_pattern(fpat_v[1]), .fail_mask(fmask_v[1]),
      .fail_count(fcnt_v[1]), .pattern(pat_v[1]));

   hex_inv_tester #(.SETTLE_CYCLES(S2), .STOP_ON_FAIL(1'b0)) u2 (
      .clock(clk), .reset(rst_v[2]), .start(start_v[2]),
      .dut_in(din_v[2]), .dut_out(dout_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .fail_pattern(fpat_v[2]), .fail_mask(fmask_v[2]),
      .fail_count(fcnt_v[2]), .pattern(pat_v[2]));

   typedef struct {
      int          cyc;
      logic [25:0] res;
   } exp_t;

   typedef struct {
      int          cyc;
      int          seq_bad;
      logic [25:0] res;
   } obs_t;

   exp_t sb[$];
   int vecs = 0;
   int errs = 0;

   function automatic int settle_of(input int i);
      return (i == 2) ? S2 : ((i == 0) ? S0 : S1);
   endfunction

   function automatic logic [25:0] snap(input int i);
      return {pass_v[i], fcnt_v[i], fpat_v[i], fmask_v[i], din_v[i]};
   endfunction

   // expected {pass, count, first pattern, mask, final dut_in} and latency
   task automatic push_model(input int i);
      exp_t e;
      logic [5:0] p, o, m, fp, fm;
      int cnt, n;
      cnt = 0; n = 0; fp = '0; fm = '0; p = '0;
      for (int k = 0; k < 64; k++) begin
         p = 6'(k);
         o = (~p & ~sa0[i]) | sa1[i];
         m = o ^ ~p;
         n = k + 1;
         if (m != 6'd0) begin
            if (cnt == 0) begin
               fp = p;
               fm = m;
            end
            cnt++;
         end
         if (i == 1 && m != 6'd0) break;
      end
      e.cyc = n * (settle_of(i) + 2);
      e.res = {cnt == 0, 7'(cnt), fp, fm, p};
      sb.push_back(e);
   endtask

   task automatic run_scan(input int i, input bit pulses, output obs_t o);
      int per;
      per = settle_of(i) + 2;
      o.cyc = 0;
      o.seq_bad = 0;
      @(negedge clk);
      start_v[i] = 1'b1;
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
      if (pat_v[i] !== 6'd0 || busy_v[i] !== 1'b1) o.seq_bad++;
      while (o.cyc < 64 * per + 20) begin
         @(posedge clk);
         o.cyc++;
         #1;
         if (done_v[i] === 1'b1) break;
         if (busy_v[i] !== 1'b1 || pat_v[i] !== 6'(o.cyc / per)) o.seq_bad++;
         start_v[i] = pulses && (o.cyc % 5 == 2) && (o.cyc < 64 * per - 4);
      end
      start_v[i] = 1'b0;
      o.res = snap(0 + i);
   endtask

   task automatic test_reset();
      rst_v = 3'b111;
      start_v = 3'b000;
      for (int i = 0; i < 3; i++) begin
         sa0[i] = '0;
         sa1[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if ({busy_v[i], done_v[i], pat_v[i], snap(i)} !== 34'd0) begin
            errs++;
            $display("FAIL reset_state[%0d]: got busy=%b done=%b pat=%h res=%h, want all 0",
                     i, busy_v[i], done_v[i], pat_v[i], snap(i));
         end
      end
      @(negedge clk);
      rst_v = 3'b000;
   endtask

   task automatic test_ideal();
      obs_t o;
      exp_t e;
      push_model(0);
      run_scan(0, 1'b0, o);
      e = sb.pop_front();
      vecs++;
      if (o.cyc !== e.cyc) begin
         errs++;
         $display("FAIL ideal_latency: got %0d cycles, want %0d", o.cyc, e.cyc);
      end
      vecs++;
      if (o.res !== e.res) begin
         errs++;
         $display("FAIL ideal_result: got pass/cnt/pat/mask/din=%h, want %h", o.res, e.res);
      end
      vecs++;
      if (o.seq_bad !== 0) begin
         errs++;
         $display("FAIL ideal_sequence: got %0d bad cycles, want 0", o.seq_bad);
      end
   endtask

   task automatic test_stuck0();
      obs_t o;
      exp_t e;
      sa0[0] = 6'h08;
      push_model(0);
      run_scan(0, 1'b0, o);
      e = sb.pop_front();
      vecs++;
      if (o.res !== e.res) begin
         errs++;
         $display("FAIL stuck0_result: got %h, want %h", o.res, e.res);
      end
      vecs++;
      if (o.cyc !== e.cyc) begin
         errs++;
         $display("FAIL stuck0_latency: got %0d, want %0d", o.cyc, e.cyc);
      end
      sa0[0] = '0;
   endtask

   task automatic test_stop_on_fail();
      obs_t o;
      exp_t e;
      sa1[1] = 6'h01;
      push_model(1);
      run_scan(1, 1'b0, o);
      e = sb.pop_front();
      vecs++;
      if (o.cyc !== e.cyc) begin
         errs++;
         $display("FAIL stop_latency: got %0d cycles, want %0d", o.cyc, e.cyc);
      end
      vecs++;
      if (o.res !== e.res) begin
         errs++;
         $display("FAIL stop_result: got %h, want %h", o.res, e.res);
      end
      sa1[1] = '0;
      push_model(1);
      run_scan(1, 1'b0, o);
      e = sb.pop_front();
      vecs++;
      if (o.cyc !== e.cyc || o.res !== e.res) begin
         errs++;
         $display("FAIL stop_clean: got cyc=%0d res=%h, want cyc=%0d res=%h",
                  o.cyc, o.res, e.cyc, e.res);
      end
   endtask

   task automatic test_no_settle();
      obs_t o;
      exp_t e;
      push_model(2);
      run_scan(2, 1'b0, o);
      e = sb.pop_front();
      vecs++;
      if (o.cyc !== e.cyc) begin
         errs++;
         $display("FAIL nosettle_latency: got %0d cycles, want %0d", o.cyc, e.cyc);
      end
      vecs++;
      if (o.res !== e.res || o.seq_bad !== 0) begin
         errs++;
         $display("FAIL nosettle_result: got res=%h bad=%0d, want res=%h bad=0",
                  o.res, o.seq_bad, e.res);
      end
   endtask

   task automatic test_mid_reset();
      obs_t o;
      exp_t e;
      int n;
      sa0[0] = 6'h08;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      n = 0;
      while (pat_v[0] !== 6'h20 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      vecs++;
      if (n >= 2000) begin
         errs++;
         $display("FAIL midreset_reach: got pattern %h, want 20", pat_v[0]);
      end
      #2;
      rst_v[0] = 1'b1;
      #1;
      vecs++;
      if ({busy_v[0], done_v[0], pat_v[0], snap(0)} !== 34'd0) begin
         errs++;
         $display("FAIL midreset_clear: got busy=%b done=%b pat=%h res=%h, want all 0",
                  busy_v[0], done_v[0], pat_v[0], snap(0));
      end
      @(negedge clk);
      rst_v[0] = 1'b0;
      sa0[0] = '0;
      push_model(0);
      run_scan(0, 1'b0, o);
      e = sb.pop_front();
      vecs++;
      if (o.cyc !== e.cyc || o.res !== e.res || o.seq_bad !== 0) begin
         errs++;
         $display("FAIL midreset_rescan: got cyc=%0d res=%h bad=%0d, want cyc=%0d res=%h bad=0",
                  o.cyc, o.res, o.seq_bad, e.cyc, e.res);
      end
   endtask

   task automatic test_busy_start();
      obs_t o;
      exp_t e;
      push_model(0);
      run_scan(0, 1'b1, o);
      e = sb.pop_front();
      vecs++;
      if (o.cyc !== e.cyc || o.seq_bad !== 0) begin
         errs++;
         $display("FAIL busy_start: got cyc=%0d bad=%0d, want cyc=%0d bad=0",
                  o.cyc, o.seq_bad, e.cyc);
      end
      vecs++;
      if (o.res !== e.res) begin
         errs++;
         $display("FAIL busy_start_result: got %h, want %h", o.res, e.res);
      end
   endtask

   task automatic test_held_start();
      exp_t e;
      int n;
      sa0[0] = 6'h08;
      push_model(0);
      push_model(0);
      @(negedge clk);
      start_v[0] = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (done_v[0] !== 1'b1 && n < 400);
      e = sb.pop_front();
      vecs++;
      if (snap(0) !== e.res) begin
         errs++;
         $display("FAIL held_first: got %h, want %h", snap(0), e.res);
      end
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      vecs++;
      if ({done_v[0], busy_v[0], fcnt_v[0], pat_v[0]} !== {1'b0, 1'b1, 7'd0, 6'd0}) begin
         errs++;
         $display("FAIL held_restart: got done=%b busy=%b cnt=%0d pat=%h, want 0 1 0 00",
                  done_v[0], busy_v[0], fcnt_v[0], pat_v[0]);
      end
      n = 0;
      while (done_v[0] !== 1'b1 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      e = sb.pop_front();
      vecs++;
      if (n !== e.cyc || snap(0) !== e.res) begin
         errs++;
         $display("FAIL held_second: got cyc=%0d res=%h, want cyc=%0d res=%h",
                  n, snap(0), e.cyc, e.res);
      end
      sa0[0] = '0;
   endtask

   task automatic test_random_faults();
      obs_t o;
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 2; i++) begin
            sa0[i] = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
            sa1[i] = 6'($urandom_range(0, 63)) & ~sa0[i];
            push_model(i);
            run_scan(i, 1'b0, o);
            e = sb.pop_front();
            vecs++;
            if (o.cyc !== e.cyc || o.res !== e.res) begin
               errs++;
               $display("FAIL random[%0d,%0d] sa0=%h sa1=%h: got cyc=%0d res=%h, want cyc=%0d res=%h",
                        k, i, sa0[i], sa1[i], o.cyc, o.res, e.cyc, e.res);
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         sa0[i] = '0;
         sa1[i] = '0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ideal();
      test_stuck0();
      test_stop_on_fail();
      test_no_settle();
      test_mid_reset();
      test_busy_start();
      test_held_start();
      test_random_faults();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
